// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared IFU widths, state encodings, output record and helpers
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
    logic            fault;
  } ifu_out_t;

  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - IMEM read channel and decode-side instruction channel
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  logic            ins_valid;
  logic            ins_ready;
  logic [31:0]     ins;
  logic [XLEN-1:0] ins_pc;
  logic            ins_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output ins_valid, ins, ins_pc, ins_fault,
    input  ins_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  ins_valid, ins, ins_pc, ins_fault,
    output ins_ready
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch FSM with flush, timeout and fault word
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INSN    = NOP_INSN_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [XLEN-1:0]    i_pc,
  output logic               o_pc_en,
  input  logic               i_flush,
  instr_fetch_unit_if.master io_bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_pc_q;
  logic             r_drop;
  logic [CNT_W-1:0] r_cnt;
  ifu_out_t         r_out;
  logic             r_ins_valid;

  logic             w_req;
  logic             w_discard;
  logic             w_timeout;

  assign w_req     = (r_state == S_REQ) && !i_flush && pc_aligned(i_pc[1:0]);
  assign w_discard = r_drop || i_flush;
  assign w_timeout = (r_cnt == CNT_LAST);

  assign o_pc_en           = w_req && io_bus.imem_gnt;
  assign io_bus.imem_req   = w_req;
  assign io_bus.imem_addr  = w_req ? i_pc : '0;
  assign io_bus.ins_valid  = r_ins_valid;
  assign io_bus.ins        = r_out.ins;
  assign io_bus.ins_pc     = r_out.pc;
  assign io_bus.ins_fault  = r_out.fault;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_pc_q      <= '0;
      r_drop      <= 1'b0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_ins_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;

        S_REQ: begin
          if (!i_flush) begin
            if (!pc_aligned(i_pc[1:0])) begin
              r_out       <= '{ins: NOP_INSN, pc: i_pc, fault: 1'b1};
              r_ins_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else if (io_bus.imem_gnt) begin
              r_pc_q  <= i_pc;
              r_cnt   <= '0;
              r_drop  <= 1'b0;
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          // Data beats the timeout; a redirect seen at any point in the wait discards the word.
          if (io_bus.imem_rvalid) begin
            r_drop <= 1'b0;
            if (w_discard) begin
              r_state <= S_REQ;
            end else begin
              r_out       <= '{ins: io_bus.imem_rdata, pc: r_pc_q, fault: 1'b0};
              r_ins_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end else if (w_timeout) begin
            r_drop <= 1'b0;
            if (w_discard) begin
              r_state <= S_REQ;
            end else begin
              r_out       <= '{ins: NOP_INSN, pc: r_pc_q, fault: 1'b1};
              r_ins_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end else if (i_flush) begin
            r_drop <= 1'b1;
          end
        end

        S_HOLD: begin
          if (i_flush || io_bus.ins_ready) begin
            r_ins_valid <= 1'b0;
            r_state     <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int          TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            i_clk = 1'b0;
  logic            i_rstn;
  logic [XLEN-1:0] i_pc;
  logic            o_pc_en;
  logic            i_flush;

  instr_fetch_unit_if u_if();

  instr_fetch_unit #(.TIMEOUT_CYC(TO), .NOP_INSN(NOP)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_pc    (i_pc),
    .o_pc_en (o_pc_en),
    .i_flush (i_flush),
    .io_bus  (u_if)
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  bit          outstanding;
  bit          dropped;
  logic [31:0] out_addr;
  int          cd;
  logic [31:0] pc_model;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic to_neg();
    @(negedge i_clk);
  endtask

  task automatic to_pos();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr, input logic pc_en);
    chk({tag, "/req"}, 32'(u_if.imem_req), 32'(req));
    if (req) chk({tag, "/addr"}, u_if.imem_addr, addr);
    chk({tag, "/pc_en"}, 32'(o_pc_en), 32'(pc_en));
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic f);
    chk({tag, "/valid"}, 32'(u_if.ins_valid), 32'(v));
    chk({tag, "/ins"}, u_if.ins, ins);
    chk({tag, "/ins_pc"}, u_if.ins_pc, pc);
    chk({tag, "/fault"}, 32'(u_if.ins_fault), 32'(f));
  endtask

  // One randomized cycle: drive memory/decode/PC stimulus and check against the transaction model.
  task automatic rnd_cycle(input bit allow_flush, input bit allow_gnt, input bit force_ready);
    bit          fl;
    bit          rv;
    logic [31:0] tgt;
    exp_t        e;
    fl  = allow_flush && ($urandom_range(15) == 0);
    tgt = 32'($urandom_range(1023)) << 2;
    rv  = outstanding && (cd == 0);
    i_flush          = fl;
    u_if.imem_gnt    = allow_gnt && ($urandom_range(1) == 1);
    u_if.ins_ready   = force_ready || ($urandom_range(2) != 0);
    u_if.imem_rvalid = rv;
    u_if.imem_rdata  = rv ? mem_word(out_addr) : $urandom();
    to_neg();
    if (u_if.imem_req) begin
      chk("rnd/addr", u_if.imem_addr, pc_model);
      chk("rnd/pc_en", 32'(o_pc_en), 32'(u_if.imem_gnt));
      chk("rnd/req_while_valid", 32'(u_if.ins_valid), 32'd0);
      if (outstanding) chk("rnd/req_while_busy", 32'(u_if.imem_req), 32'd0);
    end else begin
      chk("rnd/pc_en_no_req", 32'(o_pc_en), 32'd0);
    end
    if (u_if.ins_valid) begin
      if (exp_q.size() == 0) begin
        chk("rnd/spurious_valid", 32'(u_if.ins_valid), 32'd0);
      end else if (fl) begin
        void'(exp_q.pop_front());
      end else if (u_if.ins_ready) begin
        e = exp_q.pop_front();
        chk("rnd/ins", u_if.ins, e.ins);
        chk("rnd/ins_pc", u_if.ins_pc, e.pc);
        chk("rnd/fault", 32'(u_if.ins_fault), 32'd0);
      end
    end
    if (rv) begin
      if (!dropped && !fl) exp_q.push_back('{ins: mem_word(out_addr), pc: out_addr});
      outstanding = 1'b0;
    end else if (outstanding) begin
      if (fl) dropped = 1'b1;
      cd--;
    end
    if (o_pc_en) begin
      outstanding = 1'b1;
      dropped     = 1'b0;
      out_addr    = pc_model;
      cd          = int'($urandom_range(2));
    end
    pc_model = fl ? tgt : (o_pc_en ? pc_model + 32'd4 : pc_model);
    to_pos();
    i_pc = pc_model;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rstn = 1'b0; i_pc = '0; i_flush = 1'b0;
    u_if.imem_gnt = 1'b0; u_if.imem_rvalid = 1'b0; u_if.imem_rdata = '0; u_if.ins_ready = 1'b0;
    outstanding = 1'b0; dropped = 1'b0; cd = 0; out_addr = '0; pc_model = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_bus("reset", 1'b0, 32'h0, 1'b0);
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    i_rstn = 1'b1;
    to_neg(); chk_bus("idle", 1'b0, 32'h0, 1'b0); to_pos();

    // Basic fetch: grant in the request cycle, data one cycle later.
    i_pc = 32'h0; u_if.imem_gnt = 1'b1;
    to_neg(); chk_bus("t1_req", 1'b1, 32'h0, 1'b1); to_pos();
    i_pc = 32'h4; u_if.imem_gnt = 1'b0; u_if.imem_rvalid = 1'b1; u_if.imem_rdata = 32'h0050_0093;
    to_neg(); chk_bus("t1_wait", 1'b0, 32'h0, 1'b0); chk("t1_wait/valid", 32'(u_if.ins_valid), 32'd0); to_pos();
    u_if.imem_rvalid = 1'b0; u_if.imem_rdata = '0; u_if.imem_gnt = 1'b1;

    // Backpressure: held word stays put, no new request.
    for (int k = 0; k < 5; k++) begin
      to_neg(); chk_out("t2_hold", 1'b1, 32'h0050_0093, 32'h0, 1'b0); chk_bus("t2_hold", 1'b0, 32'h0, 1'b0); to_pos();
    end
    u_if.imem_gnt = 1'b0; u_if.ins_ready = 1'b1;
    to_neg(); chk_out("t1_accept", 1'b1, 32'h0050_0093, 32'h0, 1'b0); to_pos();
    u_if.ins_ready = 1'b0; u_if.imem_gnt = 1'b1;
    to_neg(); chk_bus("t1_next", 1'b1, 32'h4, 1'b1); to_pos();

    // Flush while waiting: the returned word must be discarded.
    i_pc = 32'h8; u_if.imem_gnt = 1'b0; i_flush = 1'b1;
    to_neg(); chk_bus("t3_flush", 1'b0, 32'h0, 1'b0); to_pos();
    i_flush = 1'b0; i_pc = 32'h100;
    to_neg(); chk("t3_wait/valid", 32'(u_if.ins_valid), 32'd0); to_pos();
    u_if.imem_rvalid = 1'b1; u_if.imem_rdata = 32'hDEAD_BEEF;
    to_neg(); chk("t3_rvalid/valid", 32'(u_if.ins_valid), 32'd0); to_pos();
    u_if.imem_rvalid = 1'b0;
    to_neg(); chk("t3_discard/valid", 32'(u_if.ins_valid), 32'd0); chk_bus("t3_refetch", 1'b1, 32'h100, 1'b0); to_pos();
    u_if.imem_gnt = 1'b1;
    to_neg(); chk_bus("t3_refetch_gnt", 1'b1, 32'h100, 1'b1); to_pos();
    i_pc = 32'h104; u_if.imem_gnt = 1'b0; u_if.imem_rvalid = 1'b1; u_if.imem_rdata = 32'h00A0_0113;
    to_pos();
    u_if.imem_rvalid = 1'b0; u_if.ins_ready = 1'b1;
    to_neg(); chk_out("t3_word", 1'b1, 32'h00A0_0113, 32'h100, 1'b0); to_pos();

    // Misaligned PC produces a fault word without touching memory.
    u_if.ins_ready = 1'b0; i_pc = 32'h102; u_if.imem_gnt = 1'b1;
    to_neg(); chk_bus("t4_misaligned", 1'b0, 32'h0, 1'b0); to_pos();
    u_if.imem_gnt = 1'b0;
    to_neg(); chk_out("t4_fault", 1'b1, NOP, 32'h102, 1'b1); to_pos();
    u_if.ins_ready = 1'b1; i_pc = 32'h200;
    to_neg(); chk_out("t4_fault_stable", 1'b1, NOP, 32'h102, 1'b1); to_pos();

    // Timeout: no response within TO cycles gives a fault word at the granted PC.
    u_if.ins_ready = 1'b0; u_if.imem_gnt = 1'b1;
    to_neg(); chk_bus("t5_req", 1'b1, 32'h200, 1'b1); to_pos();
    u_if.imem_gnt = 1'b0; i_pc = 32'h204;
    for (int k = 0; k < TO; k++) begin
      to_neg(); chk("t5_wait/valid", 32'(u_if.ins_valid), 32'd0); to_pos();
    end
    to_neg(); chk_out("t5_timeout", 1'b1, NOP, 32'h200, 1'b1); to_pos();
    u_if.imem_rvalid = 1'b1; u_if.imem_rdata = 32'hCAFE_F00D;
    to_neg(); chk_out("t5_late", 1'b1, NOP, 32'h200, 1'b1); to_pos();
    u_if.imem_rvalid = 1'b0; u_if.ins_ready = 1'b1;
    to_neg(); chk_out("t5_late_ignored", 1'b1, NOP, 32'h200, 1'b1); to_pos();

    // Reset in the middle of a wait abandons the request.
    u_if.ins_ready = 1'b0; u_if.imem_gnt = 1'b1;
    to_neg(); chk_bus("t6_req", 1'b1, 32'h204, 1'b1); to_pos();
    u_if.imem_gnt = 1'b0; i_pc = 32'h208;
    to_pos();
    i_rstn = 1'b0; i_pc = 32'h300;
    #1;
    chk_bus("t6_reset", 1'b0, 32'h0, 1'b0);
    chk_out("t6_reset", 1'b0, 32'h0, 32'h0, 1'b0);
    to_pos();
    i_rstn = 1'b1; u_if.imem_rvalid = 1'b1; u_if.imem_rdata = 32'h1234_5678;
    to_neg(); chk_bus("t6_idle", 1'b0, 32'h0, 1'b0); chk("t6_idle/valid", 32'(u_if.ins_valid), 32'd0); to_pos();
    u_if.imem_rvalid = 1'b0;
    to_neg(); chk("t6_no_late/valid", 32'(u_if.ins_valid), 32'd0); chk_bus("t6_fresh", 1'b1, 32'h300, 1'b0); to_pos();

    // Randomized traffic against the transaction-level model.
    pc_model = 32'h300; outstanding = 1'b0; dropped = 1'b0; exp_q.delete();
    for (int k = 0; k < 3000; k++) rnd_cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (!outstanding && exp_q.size() == 0 && !u_if.ins_valid) break;
      rnd_cycle(1'b0, 1'b0, 1'b1);
    end
    chk("drain/queue", 32'(exp_q.size()), 32'd0);
    chk("drain/valid", 32'(u_if.ins_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
